// File: rtl/poly_reduce.sv
// poly_reduce: folds the raw product of the polynomial multiplier modulo
// x^757 - x - 1 and reduces every coefficient modulo q.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a reduction (sampled in IDLE only)
//   deg        degree of the product held in product memory (0..1512)
//   prod_addr  product memory read address
//   prod_data  product memory read data, valid one cycle after prod_addr
//   out_addr   result memory write address (0..P-1)
//   out_data   reduced coefficient (0..Q-1)
//   out_we     result memory write strobe, one pulse per coefficient
//   busy       reduction in progress
//   done       completion level, cleared by the next accepted start
module poly_reduce #(
    parameter int unsigned P         = 757,
    parameter int unsigned Q         = 4591,
    parameter int unsigned MOD_STEPS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] deg,
    output logic [10:0] prod_addr,
    input  logic [25:0] prod_data,
    output logic [9:0]  out_addr,
    output logic [12:0] out_data,
    output logic        out_we,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW    = 11;
    localparam int unsigned JW    = 10;
    localparam int unsigned CW    = 13;
    localparam int unsigned ACC_W = 28;
    localparam int unsigned SW    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_RD_C,
        S_ACC,
        S_MOD,
        S_WR,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [JW-1:0]      j, j_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [SW-1:0]      s, s_n;
    logic [AW-1:0]      prod_addr_n;
    logic [JW-1:0]      out_addr_n;
    logic [CW-1:0]      out_data_n;
    logic               out_we_n;
    logic               busy_n;
    logic               done_n;

    logic [AW-1:0]      addr_lo;
    logic [AW-1:0]      addr_hi;
    logic [AW-1:0]      addr_mid;
    logic [ACC_W-1:0]   data_ext;
    logic [ACC_W-1:0]   sum;

    // One restoring-subtraction step against Q shifted left by sh.
    function automatic logic [ACC_W-1:0] mod_step(input logic [ACC_W-1:0] a,
                                                  input logic [SW-1:0]    sh);
        logic [ACC_W-1:0] qs;
        qs = ACC_W'(Q) << sh;
        return (a >= qs) ? (a - qs) : a;
    endfunction

    // Read addresses of the three terms that fold into coefficient j.
    assign addr_lo  = AW'(j);
    assign addr_hi  = AW'(j) + AW'(P);
    assign addr_mid = AW'(j) + AW'(P - 1);
    assign data_ext = ACC_W'(prod_data);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            j         <= '0;
            acc       <= '0;
            s         <= '0;
            prod_addr <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            out_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            j         <= j_n;
            acc       <= acc_n;
            s         <= s_n;
            prod_addr <= prod_addr_n;
            out_addr  <= out_addr_n;
            out_data  <= out_data_n;
            out_we    <= out_we_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so that the registered values line up with the state they
    // belong to.
    always_comb begin
        state_n     = state;
        j_n         = j;
        acc_n       = acc;
        s_n         = s;
        prod_addr_n = prod_addr;
        out_addr_n  = out_addr;
        out_data_n  = out_data;
        out_we_n    = 1'b0;
        busy_n      = busy;
        done_n      = done;
        sum         = '0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_RD_A;
                    j_n         = '0;
                    acc_n       = '0;
                    done_n      = 1'b0;
                    busy_n      = 1'b1;
                    prod_addr_n = '0;
                end
            end
            S_RD_A: begin
                state_n     = S_RD_B;
                prod_addr_n = addr_hi;
            end
            S_RD_B: begin
                // data for c_j
                if (addr_lo <= deg) begin
                    acc_n = acc + data_ext;
                end
                state_n     = S_RD_C;
                prod_addr_n = addr_mid;
            end
            S_RD_C: begin
                // data for c_{757+j}
                if (addr_hi <= deg) begin
                    acc_n = acc + data_ext;
                end
                state_n = S_ACC;
            end
            S_ACC: begin
                // data for c_{756+j}; the s=15 subtraction step rides along
                // with the last add so that a coefficient costs 20 cycles.
                sum = acc;
                if ((j != '0) && (addr_mid <= deg)) begin
                    sum = acc + data_ext;
                end
                acc_n   = mod_step(sum, SW'(MOD_STEPS - 1));
                s_n     = SW'(MOD_STEPS - 2);
                state_n = S_MOD;
            end
            S_MOD: begin
                acc_n = mod_step(acc, s);
                if (s == '0) begin
                    state_n    = S_WR;
                    out_we_n   = 1'b1;
                    out_addr_n = j;
                    out_data_n = acc_n[CW-1:0];
                end else begin
                    s_n = s - SW'(1);
                end
            end
            S_WR: begin
                if (j == JW'(P - 1)) begin
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                end else begin
                    j_n         = j + JW'(1);
                    acc_n       = '0;
                    prod_addr_n = AW'(j) + AW'(1);
                    state_n     = S_RD_A;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_poly_reduce.sv
// Self-checking bench for poly_reduce: directed table runs (chained
// back-to-back), an aborted run with ignored starts and a mid-run reset,
// and a randomized full run, all compared against an arithmetic model.
module tb_poly_reduce;

    localparam int NP   = 757;
    localparam int NQ   = 4591;
    localparam int MAXK = 1512;
    localparam int RUN_CYC = 15142;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] deg;
    logic [10:0] prod_addr;
    logic [25:0] prod_data;
    logic [9:0]  out_addr;
    logic [12:0] out_data;
    logic        out_we;
    logic        busy;
    logic        done;

    logic [25:0] mem [0:MAXK];
    logic [12:0] res [0:NP-1];

    int n_vec;
    int n_bad;

    poly_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .deg       (deg),
        .prod_addr (prod_addr),
        .prod_data (prod_data),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_we    (out_we),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product memory with one-cycle read latency.
    always @(posedge clk) begin
        if (int'(prod_addr) <= MAXK) prod_data <= mem[prod_addr];
        else                         prod_data <= '0;
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // r_j from the folding identity x^757 = x + 1, entries above deg = 0.
    function automatic int model_r(input int jj, input int dg);
        longint sum;
        sum = 0;
        if (jj <= dg)                    sum += longint'(mem[jj]);
        if (NP + jj <= dg)               sum += longint'(mem[NP + jj]);
        if (jj >= 1 && NP - 1 + jj <= dg) sum += longint'(mem[NP - 1 + jj]);
        return int'(sum % NQ);
    endfunction

    // fill: 0 zeros, 1 all 2^26-1, 2 random; then one entry forced.
    task automatic load_mem(input int fill, input int a0, input int v0);
        for (int k = 0; k <= MAXK; k++) begin
            if (fill == 0)      mem[k] = '0;
            else if (fill == 1) mem[k] = 26'h3FFFFFF;
            else                mem[k] = 26'($urandom);
        end
        mem[a0] = 26'(v0);
        for (int k = 0; k < NP; k++) res[k] = 13'h1FFF;
    endtask

    // Caller is #1 after a posedge with the DUT idle. abort_at=0 runs to
    // completion and checks everything; otherwise reset is hit at that cycle.
    task automatic do_run(input int abort_at, input bit pulse, output int wr_cnt);
        int cyc;
        int done_cyc;
        int bad_a;
        int bad_t;
        int nmis;
        int first;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        wr_cnt = 0; bad_a = 0; bad_t = 0; done_cyc = -1;
        chk("busy_cycle1", busy, 1);
        chk("done_cleared", done, 0);
        while (cyc < 16000) begin
            if (out_we) begin
                if (int'(out_addr) != wr_cnt) bad_a++;
                if (cyc != 20 * (wr_cnt + 1)) bad_t++;
                if (int'(out_addr) < NP) res[out_addr] = out_data;
                wr_cnt++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = pulse && (cyc == 5 || cyc == 3000);
            if (cyc == abort_at) begin
                start = 1'b0;
                #2 rst = 1'b1;
                #1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("wr_addr_order_errs", bad_a, 0);
        chk("wr_timing_errs", bad_t, 0);
        if (abort_at == 0) begin
            chk("done_cycle", done_cyc, RUN_CYC);
            chk("busy_at_done", busy, 0);
            chk("write_count", wr_cnt, NP);
            nmis = 0; first = -1;
            for (int jj = 0; jj < NP; jj++) begin
                if (int'(res[jj]) != model_r(jj, int'(deg))) begin
                    nmis++;
                    if (first < 0) first = jj;
                end
            end
            if (nmis != 0)
                $display("first bad coefficient %0d: got %0d want %0d",
                         first, res[first], model_r(first, int'(deg)));
            chk("coef_mismatches", nmis, 0);
        end
    endtask

    typedef struct {
        int deg;
        int fill;
        int a0;
        int v0;
        int i0; int e0;
        int i1; int e1;
        int i2; int e2;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int wr;
        int we_seen;
        n_vec = 0;
        n_bad = 0;
        tbl[0] = '{757,  0, 757,  1,        0, 1,    1, 1,    2,   0};
        tbl[1] = '{1512, 0, 1512, 1,        755, 1,  756, 1,  0,   0};
        tbl[2] = '{1512, 1, 0,    67108863, 0, 4432, 1, 2057, 756, 4432};
        tbl[3] = '{0,    2, 0,    4592,     0, 1,    1, 0,    756, 0};

        rst = 1'b1;
        start = 1'b0;
        deg = '0;
        load_mem(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prod_addr", prod_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed runs, each started in the IDLE cycle right after DONE.
        for (int i = 0; i < 4; i++) begin
            load_mem(tbl[i].fill, tbl[i].a0, tbl[i].v0);
            deg = 11'(tbl[i].deg);
            do_run(0, 1'b0, wr);
            chk($sformatf("tbl%0d_r%0d", i, tbl[i].i0), res[tbl[i].i0], tbl[i].e0);
            chk($sformatf("tbl%0d_r%0d", i, tbl[i].i1), res[tbl[i].i1], tbl[i].e1);
            chk($sformatf("tbl%0d_r%0d", i, tbl[i].i2), res[tbl[i].i2], tbl[i].e2);
        end

        // Stray starts during a run, then reset at cycle 6000.
        load_mem(2, 0, int'($urandom_range(100, 0)));
        deg = 11'($urandom_range(MAXK, 0));
        do_run(6000, 1'b1, wr);
        chk("abort_writes", wr, 300);
        chk("abort_out_we", out_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_prod_addr", prod_addr, 0);
        we_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_we || busy) we_seen++;
        end
        chk("quiet_in_reset", we_seen, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomized full run after reset, with junk above deg.
        load_mem(2, 900, 5);
        deg = 11'($urandom_range(MAXK, 700));
        do_run(0, 1'b0, wr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
